// File: rtl/mac_sat_accum_if.sv
// Bundles the M-stage product and pipeline controls with the W-stage accumulator results.
interface mac_sat_accum_if #(
  parameter int unsigned ACCW = 16,
  parameter int unsigned CNTW = 8
);
  // Pipeline controls from the hazard unit
  logic            StallM;
  logic            FlushM;
  // Product from the multiplier
  logic            ValidM;
  logic            ClrM;
  logic [31:0]     ProdM;
  logic            VM;
  // Results towards writeback
  logic [ACCW-1:0] AccW;
  logic            SatW;
  logic [CNTW-1:0] CntW;
  logic            ValidW;

  // Producer side: drives controls and products, observes results
  modport master (
    output StallM, FlushM, ValidM, ClrM, ProdM, VM,
    input  AccW, SatW, CntW, ValidW
  );

  // Accumulator side
  modport slave (
    input  StallM, FlushM, ValidM, ClrM, ProdM, VM,
    output AccW, SatW, CntW, ValidW
  );
endinterface

// File: rtl/mac_sat_accum.sv
// Saturating multiply-accumulate back end: registers the multiplier product (stage A),
// then adds it into an unsigned accumulator that clamps at all-ones (stage W).
module mac_sat_accum #(
  parameter int unsigned ACCW = 16,
  parameter int unsigned CNTW = 8
) (
  input  logic           clk,
  input  logic           reset,
  mac_sat_accum_if.slave bus
);

  localparam int unsigned PRODW = 32;
  localparam int unsigned SUMW  = PRODW + 1;

  // Stage A state
  logic             valid_a;
  logic             clr_a;
  logic             v_a;
  logic [PRODW-1:0] prod_a;

  // Stage W state
  logic [ACCW-1:0]  acc_w;
  logic             sat_w;
  logic [CNTW-1:0]  cnt_w;
  logic             valid_w;

  // Next-state terms for stage W
  logic             fire;
  logic [ACCW-1:0]  base;
  logic [SUMW-1:0]  sum;
  logic             clamp;
  logic [ACCW-1:0]  acc_nxt;
  logic             sat_nxt;
  logic [CNTW-1:0]  cnt_nxt;

  // Stage A capture; flush kills the valid bit even while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_a <= 1'b0;
      clr_a   <= 1'b0;
      v_a     <= 1'b0;
      prod_a  <= '0;
    end else begin
      if (bus.FlushM) begin
        valid_a <= 1'b0;
      end else if (!bus.StallM) begin
        valid_a <= bus.ValidM;
      end
      if (!bus.StallM) begin
        clr_a  <= bus.ClrM;
        v_a    <= bus.VM;
        prod_a <= bus.ProdM;
      end
    end
  end

  // Accumulate: 33-bit sum so any carry or wide product forces the clamp
  always_comb begin
    fire    = valid_a && !bus.StallM && !bus.FlushM;
    base    = clr_a ? '0 : acc_w;
    sum     = SUMW'(prod_a) + SUMW'(base);
    clamp   = |sum[SUMW-1:ACCW];
    acc_nxt = clamp ? '1 : sum[ACCW-1:0];
    sat_nxt = (clr_a ? 1'b0 : sat_w) | v_a | clamp;
    if (clr_a) begin
      cnt_nxt = CNTW'(1);
    end else if (&cnt_w) begin
      cnt_nxt = cnt_w;
    end else begin
      cnt_nxt = cnt_w + CNTW'(1);
    end
  end

  // Stage W registers; results hold whenever no product is consumed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_w   <= '0;
      sat_w   <= 1'b0;
      cnt_w   <= '0;
      valid_w <= 1'b0;
    end else begin
      valid_w <= fire;
      if (fire) begin
        acc_w <= acc_nxt;
        sat_w <= sat_nxt;
        cnt_w <= cnt_nxt;
      end
    end
  end

  assign bus.AccW   = acc_w;
  assign bus.SatW   = sat_w;
  assign bus.CntW   = cnt_w;
  assign bus.ValidW = valid_w;

endmodule
